// File: rtl/rv32i_types.sv
// Shared RV32I types for the memory access unit: FSM states, load/store funct3
// encodings, lane masks and the alignment/legality helpers.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mau_state_t;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b100,
        LD_HU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        ST_B = 3'b000,
        ST_H = 3'b001,
        ST_W = 3'b010
    } store_funct3_t;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic access_legal(input logic write, input logic [2:0] funct3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (write) begin
            case (funct3)
                ST_B:    ok = 1'b1;
                ST_H:    ok = ~off[0];
                ST_W:    ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (funct3)
                LD_B, LD_BU: ok = 1'b1;
                LD_H, LD_HU: ok = ~off[0];
                LD_W:        ok = (off == 2'b00);
                default:     ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Loads always fetch the whole word; the byte/half is picked out on return.
    function automatic logic [3:0] lane_mask(input logic write, input logic [2:0] funct3,
                                             input logic [1:0] off);
        logic [3:0] m;
        m = MASK_W;
        if (write) begin
            case (funct3)
                ST_B:    m = MASK_B << off;
                ST_H:    m = MASK_H << off;
                default: m = MASK_W;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment: shifts the addressed lane down to bit 0
// and applies sign or zero extension according to the load funct3.
module load_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        data_o = shifted;
        case (funct3_i)
            LD_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            LD_BU:   data_o = {24'h0, shifted[7:0]};
            LD_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            LD_HU:   data_o = {16'h0, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the multicycle datapath and the unified memory port:
// issues aligned word accesses, waits on mem_resp, returns extended load data.
module mem_access_unit
    import rv32i_types::*;
#(
    parameter int MAX_WAIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output mau_state_t  dbg_state
);

    localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    // Handshake: a request is taken on any rising edge where req_valid & req_ready;
    // the unit then answers with exactly one resp_valid pulse before taking another.

    mau_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [2:0]    funct3_q;
    logic [1:0]    off_q;
    logic          write_q;
    logic          mem_read_q;
    logic          mem_write_q;
    logic [31:0]   mem_address_q;
    logic [31:0]   mem_wdata_q;
    logic [3:0]    mem_be_q;
    logic          resp_valid_q;
    logic          resp_err_q;
    logic [31:0]   resp_rdata_q;

    logic          legal;
    logic          timeout;
    logic [31:0]   load_data;

    assign legal   = access_legal(req_write, req_funct3, req_addr[1:0]);
    assign timeout = (MAX_WAIT != 0) && (cnt_q == LAST_CNT);
    assign cnt_d   = cnt_q + 1'b1;

    load_align u_load_align (
        .funct3_i (funct3_q),
        .off_i    (off_q),
        .rdata_i  (mem_rdata),
        .data_o   (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            funct3_q      <= 3'b000;
            off_q         <= 2'b00;
            write_q       <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= 32'h0;
            mem_wdata_q   <= 32'h0;
            mem_be_q      <= 4'h0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    if (req_valid) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        off_q    <= req_addr[1:0];
                        cnt_q    <= '0;
                        if (legal) begin
                            state_q       <= ACCESS;
                            mem_address_q <= {req_addr[31:2], 2'b00};
                            mem_be_q      <= lane_mask(req_write, req_funct3, req_addr[1:0]);
                            mem_wdata_q   <= req_wdata << {req_addr[1:0], 3'b000};
                            mem_read_q    <= ~req_write;
                            mem_write_q   <= req_write;
                        end else begin
                            // Illegal requests never touch memory; answer straight away.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_resp) begin
                        state_q      <= RESP;
                        mem_read_q   <= 1'b0;
                        mem_write_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        if (!write_q) begin
                            resp_rdata_q <= load_data;
                        end
                    end else if (timeout) begin
                        state_q      <= RESP;
                        mem_read_q   <= 1'b0;
                        mem_write_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign resp_valid      = resp_valid_q;
    assign resp_err        = resp_err_q;
    assign resp_rdata      = resp_rdata_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = mem_address_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_byte_enable = mem_be_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (MAX_WAIT = 4).
module tb_mem_access_unit;
    import rv32i_types::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    mau_state_t  dbg_state;

    int passed;
    int total;

    mem_access_unit #(.MAX_WAIT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_err        (resp_err),
        .resp_rdata      (resp_rdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .dbg_state       (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // All driver tasks start and end just after a falling edge.
    task automatic send_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        req_write  = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic complete_with(input logic [31:0] d);
        mem_resp  = 1'b1;
        mem_rdata = d;
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = $urandom;
    endtask

    task automatic test_reset();
        total++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else passed++;
        total++; if ({mem_read, mem_write, resp_valid, resp_err} !== 4'b0000)
            $display("FAIL reset_strobes: got %b want 0000", {mem_read, mem_write, resp_valid, resp_err});
        else passed++;
        total++; if ({mem_address, mem_wdata, resp_rdata} !== 96'h0)
            $display("FAIL reset_data: addr %h wdata %h rdata %h want 0", mem_address, mem_wdata, resp_rdata);
        else passed++;
        total++; if (mem_byte_enable !== 4'h0) $display("FAIL reset_be: got %b want 0000", mem_byte_enable); else passed++;
        total++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", dbg_state); else passed++;
    endtask

    task automatic test_lb();
        send_req(1'b0, 3'b000, 32'h4000_0003, 32'h0);
        total++; if (mem_read !== 1'b1 || mem_write !== 1'b0)
            $display("FAIL lb_strobe: read %b write %b want 1 0", mem_read, mem_write);
        else passed++;
        total++; if (mem_address !== 32'h4000_0000) $display("FAIL lb_addr: got %h want 40000000", mem_address); else passed++;
        total++; if (mem_byte_enable !== 4'b1111) $display("FAIL lb_be: got %b want 1111", mem_byte_enable); else passed++;
        total++; if (req_ready !== 1'b0) $display("FAIL lb_busy: got %b want 0", req_ready); else passed++;
        @(negedge clk);
        total++; if (resp_valid !== 1'b0 || mem_read !== 1'b1)
            $display("FAIL lb_wait: resp_valid %b mem_read %b want 0 1", resp_valid, mem_read);
        else passed++;
        complete_with(32'h80FF_1234);
        total++; if (resp_valid !== 1'b1 || resp_err !== 1'b0)
            $display("FAIL lb_resp: valid %b err %b want 1 0", resp_valid, resp_err);
        else passed++;
        total++; if (resp_rdata !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h want ffffff80", resp_rdata); else passed++;
        total++; if (mem_read !== 1'b0) $display("FAIL lb_drop: got %b want 0", mem_read); else passed++;
        @(negedge clk);
        total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL lb_pulse: valid %b ready %b want 0 1", resp_valid, req_ready);
        else passed++;
    endtask

    task automatic test_load_table();
        logic [2:0]  f_t [5] = '{3'b100, 3'b000, 3'b010, 3'b101, 3'b001};
        logic [31:0] a_t [5] = '{32'h4000_0001, 32'h4000_0000, 32'h4000_0004, 32'h4000_0002, 32'h4000_0002};
        logic [31:0] d_t [5] = '{32'h1234_F0AA, 32'h0000_007F, 32'hCAFE_BABE, 32'hBEEF_0001, 32'hBEEF_0001};
        logic [31:0] e_t [5] = '{32'h0000_00F0, 32'h0000_007F, 32'hCAFE_BABE, 32'h0000_BEEF, 32'hFFFF_BEEF};
        logic [31:0] ea;
        for (int i = 0; i < 5; i++) begin
            send_req(1'b0, f_t[i], a_t[i], $urandom);
            ea = {a_t[i][31:2], 2'b00};
            total++; if (mem_address !== ea) $display("FAIL load%0d_addr: got %h want %h", i, mem_address, ea); else passed++;
            complete_with(d_t[i]);
            total++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== e_t[i])
                $display("FAIL load%0d_resp: valid %b err %b data %h want 1 0 %h", i, resp_valid, resp_err, resp_rdata, e_t[i]);
            else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_store();
        send_req(1'b1, 3'b000, 32'h4000_0101, 32'h0000_00AB);
        for (int c = 0; c < 3; c++) begin
            total++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_byte_enable !== 4'b0010 ||
                         mem_wdata !== 32'h0000_AB00 || mem_address !== 32'h4000_0100)
                $display("FAIL sb_hold%0d: wr %b rd %b be %b wdata %h addr %h want 1 0 0010 0000ab00 40000100",
                         c, mem_write, mem_read, mem_byte_enable, mem_wdata, mem_address);
            else passed++;
            if (c < 2) @(negedge clk);
        end
        complete_with($urandom);
        total++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || mem_write !== 1'b0)
            $display("FAIL sb_resp: valid %b err %b wr %b want 1 0 0", resp_valid, resp_err, mem_write);
        else passed++;
        total++; if (resp_rdata !== 32'hFFFF_BEEF) $display("FAIL sb_keep_rdata: got %h want ffffbeef", resp_rdata); else passed++;
        @(negedge clk);
        send_req(1'b1, 3'b001, 32'h0000_0012, 32'h1234_CAFE);
        total++; if (mem_byte_enable !== 4'b1100 || mem_wdata !== 32'hCAFE_0000 || mem_address !== 32'h0000_0010)
            $display("FAIL sh_lanes: be %b wdata %h addr %h want 1100 cafe0000 00000010", mem_byte_enable, mem_wdata, mem_address);
        else passed++;
        complete_with($urandom);
        @(negedge clk);
    endtask

    task automatic test_illegal();
        logic        w_t [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [2:0]  f_t [9] = '{3'b010, 3'b011, 3'b001, 3'b001, 3'b100, 3'b110, 3'b111, 3'b101, 3'b010};
        logic [31:0] a_t [9] = '{32'h4000_0006, 32'h0, 32'h41, 32'h3, 32'h0, 32'h0, 32'h0, 32'h1, 32'h2};
        for (int i = 0; i < 9; i++) begin
            send_req(w_t[i], f_t[i], a_t[i], $urandom);
            total++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0)
                $display("FAIL illegal%0d: valid %b err %b rd %b wr %b want 1 1 0 0", i, resp_valid, resp_err, mem_read, mem_write);
            else passed++;
            @(negedge clk);
            total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0)
                $display("FAIL illegal%0d_after: valid %b ready %b rd %b wr %b want 0 1 0 0", i, resp_valid, req_ready, mem_read, mem_write);
            else passed++;
        end
        total++; if (resp_rdata !== 32'hFFFF_BEEF) $display("FAIL illegal_keep_rdata: got %h want ffffbeef", resp_rdata); else passed++;
    endtask

    task automatic test_timeout();
        int high_cnt;
        high_cnt = 0;
        send_req(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (resp_valid === 1'b1) break;
            if (mem_read === 1'b1) high_cnt++;
            @(negedge clk);
        end
        total++; if (high_cnt != 4) $display("FAIL timeout_len: got %0d want 4", high_cnt); else passed++;
        total++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || mem_read !== 1'b0)
            $display("FAIL timeout_resp: valid %b err %b rd %b want 1 1 0", resp_valid, resp_err, mem_read);
        else passed++;
        total++; if (resp_rdata !== 32'hFFFF_BEEF) $display("FAIL timeout_keep_rdata: got %h want ffffbeef", resp_rdata); else passed++;
        @(negedge clk);
        send_req(1'b0, 3'b010, 32'h0000_0200, 32'h0);
        repeat (3) @(negedge clk);
        total++; if (mem_read !== 1'b1) $display("FAIL late_resp_read: got %b want 1", mem_read); else passed++;
        complete_with(32'h1122_3344);
        total++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h1122_3344)
            $display("FAIL late_resp: valid %b err %b data %h want 1 0 11223344", resp_valid, resp_err, resp_rdata);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL idle_resp_ignored: valid %b ready %b want 0 1", resp_valid, req_ready);
        else passed++;
        send_req(1'b0, 3'b010, 32'h4000_0010, 32'h0);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h8000_0000;
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (mem_address !== 32'h4000_0010 || mem_read !== 1'b1 || mem_write !== 1'b0)
            $display("FAIL busy_req_ignored: addr %h rd %b wr %b want 40000010 1 0", mem_address, mem_read, mem_write);
        else passed++;
        complete_with(32'h0BAD_F00D);
        total++; if (resp_rdata !== 32'h0BAD_F00D) $display("FAIL b2b_first: got %h want 0badf00d", resp_rdata); else passed++;
        @(negedge clk);
        send_req(1'b0, 3'b100, 32'h4000_0013, 32'h0);
        total++; if (mem_read !== 1'b1) $display("FAIL b2b_accept: got %b want 1", mem_read); else passed++;
        complete_with(32'h9A00_0000);
        total++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_009A)
            $display("FAIL b2b_second: valid %b data %h want 1 0000009a", resp_valid, resp_rdata);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        send_req(1'b0, 3'b010, 32'h0000_0040, 32'h0);
        total++; if (mem_read !== 1'b1) $display("FAIL mid_pre_read: got %b want 1", mem_read); else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if (mem_read !== 1'b0) $display("FAIL mid_async_drop: got %b want 0", mem_read); else passed++;
        @(negedge clk);
        total++; if (resp_valid !== 1'b0 || mem_read !== 1'b0)
            $display("FAIL mid_no_resp: valid %b rd %b want 0 0", resp_valid, mem_read);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL mid_release: valid %b ready %b want 0 1", resp_valid, req_ready);
        else passed++;
        send_req(1'b0, 3'b010, 32'h0000_0008, 32'h0);
        complete_with(32'hDEAD_BEEF);
        total++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'hDEAD_BEEF)
            $display("FAIL mid_next_lw: valid %b err %b data %h want 1 0 deadbeef", resp_valid, resp_err, resp_rdata);
        else passed++;
        @(negedge clk);
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_rdata  = 32'h0;
        mem_resp   = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_lb();
        test_load_table();
        test_store();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the multicycle control/datapath and the unified memory port.
- Accepts one load or store request per transaction and drives `mem_read`/`mem_write` with a word-aligned address, byte enables and lane-shifted write data.
- Waits on `mem_resp`, then returns aligned, sign- or zero-extended load data for the datapath's `regfilemux` `lb`/`lbu`/`lh`/`lhu`/`lw` inputs.
- Flags misaligned accesses, illegal `funct3` encodings and timeouts instead of issuing them.

Parameters:
- MAX_WAIT, 1024: cycles in ACCESS without `mem_resp` before timeout error; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  in  1  control requests a memory access
- req_ready  out  1  unit idle; request accepted when `req_valid & req_ready`
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store `funct3` (lb/lh/lw/lbu/lhu; sb/sh/sw)
- req_addr  in  32  byte address (ALU output)
- req_wdata  in  32  store data (`rs2` value, unshifted)
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with `resp_valid`; 1 = misaligned, illegal `funct3` or timeout
- resp_rdata  out  32  extended load data; held until next load completion
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  32  `{req_addr[31:2], 2'b00}`
- mem_wdata  out  32  store data shifted to byte lane
- mem_byte_enable  out  4  lane mask
- mem_rdata  in  32  memory read data
- mem_resp  in  1  memory completion, single cycle

Behaviour:
- All state and outputs are flops cleared asynchronously when `rst` = 0.
  - Reset values: state IDLE; `mem_read`/`mem_write`/`resp_valid`/`resp_err` = 0; `mem_address`/`mem_wdata`/`resp_rdata` = 0; `mem_byte_enable` = 0.
  - `req_ready` = (state == IDLE), combinational.
- States:
  - IDLE → ACCESS on an accepted legal request.
  - IDLE → RESP on an accepted illegal request (`resp_err` = 1, no memory strobe).
  - ACCESS → RESP on `mem_resp`.
  - ACCESS → RESP on timeout.
  - RESP → IDLE unconditionally.
- Legality:
  - lw/sw require `addr[1:0]` = 0.
  - lh/lhu/sh require `addr[0]` = 0.
  - Bytes are always aligned.
  - Load `funct3` 011/110/111 and store `funct3` ≥ 011 are illegal.
- Accept edge registers `mem_address`, `mem_byte_enable`, `mem_wdata`, and asserts `mem_read` or `mem_write` from the next cycle. Strobes and address stay constant throughout ACCESS.
- Store lanes, with off = `addr[1:0]`:
  - sb: enable `4'b0001 << off`
  - sh: enable `4'b0011 << off`
  - sw: enable `4'b1111`
  - `mem_wdata` = `req_wdata << (8*off)`.
- Loads drive `mem_byte_enable` = `4'b1111`.
- Load extraction on the `mem_resp` cycle: s = `mem_rdata >> (8*off)`.
  - lb: `sext(s[7:0])`
  - lbu: `zext(s[7:0])`
  - lh: `sext(s[15:0])`
  - lhu: `zext(s[15:0])`
  - lw: `s`
  - Result is registered into `resp_rdata`. Stores and errors leave `resp_rdata` unchanged.
- Exiting ACCESS: the strobe deasserts on the same edge that captures `mem_resp`. `resp_valid` = 1 for exactly the RESP cycle.
- Latency:
  - Accept at edge E0, `mem_resp` high in cycle k: `resp_valid` in cycle k+1.
  - Illegal request: `resp_valid` in the cycle after E0.
- Timeout: wait counter clears on entry to ACCESS. When it reaches MAX_WAIT−1 without `mem_resp`, strobes drop and RESP is entered with `resp_err` = 1. `mem_resp` in that same cycle wins (normal completion).
- `mem_resp` outside ACCESS is ignored. `req_valid` outside IDLE is ignored. Request inputs need only be valid in the accept cycle.
- Reset mid-ACCESS: strobes drop immediately and asynchronously. No `resp_valid` is produced. Next request starts cleanly.

Decomposition:
- Shared package `rv32i_types`, extended with:
  - `mau_state_t` enum (IDLE, ACCESS, RESP)
  - load/store `funct3` enums
  - localparam lane masks
- Sub-module: `load_align`, combinational shift plus sign/zero extension (`funct3`, offset, `mem_rdata` → 32-bit word).

Test Plan:
- lb, addr `0x40000003`, `mem_rdata` = `0x80FF1234`, `mem_resp` after 2 cycles → `mem_address` = `0x40000000`, `resp_rdata` = `0xFFFFFF80`, `resp_err` = 0, `resp_valid` 1 cycle after `mem_resp`.
- lhu, addr `0x40000002`, `mem_rdata` = `0xBEEF0001` → `resp_rdata` = `0x0000BEEF`; same with lh → `0xFFFFBEEF`.
- sb, addr `0x40000101`, `req_wdata` = `0x000000AB` → `mem_write` = 1, `mem_byte_enable` = `4'b0010`, `mem_wdata` = `0x0000AB00`, held until `mem_resp`.
- sw, addr `0x40000006` → no `mem_write` ever; `resp_valid` = 1 and `resp_err` = 1 the cycle after accept; load funct3 = 011 gives the same result.
- MAX_WAIT = 4, lw with no `mem_resp` → `mem_read` high 4 cycles, then drops, and `resp_err` = 1; repeat with `mem_resp` in the 4th cycle → normal completion, `resp_err` = 0.
- Drive `rst` low during ACCESS → `mem_read` low immediately, no `resp_valid`; after release `req_ready` = 1 and the next lw completes normally.
